// File: rtl/ram512x36_fifo_ctl.sv
`default_nettype none
// ============================================================================
// Module   : ram512x36_fifo_ctl
// Brief    : FIFO controller around a 512x36 dual-port RAM (A write, B read);
//            the RAM output latch acts as a 513th head slot.
// Revision : 1.0 - initial release
// ============================================================================
module ram512x36_fifo_ctl #(
    parameter int AFULL_THRESH  = 480,
    parameter int AEMPTY_THRESH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        wr_valid,
    input  logic [35:0] wr_data,
    output logic        wr_ready,
    output logic        rd_valid,
    output logic [35:0] rd_data,
    input  logic        rd_ready,
    output logic [9:0]  count,
    output logic        afull,
    output logic        aempty,
    output logic        ovf_err,
    output logic        ram_ena,
    output logic        ram_wea,
    output logic [8:0]  ram_addra,
    output logic [31:0] ram_dia,
    output logic [3:0]  ram_dipa,
    output logic        ram_enb,
    output logic [8:0]  ram_addrb,
    input  logic [31:0] ram_dob,
    input  logic [3:0]  ram_dopb
);

    localparam logic [9:0] c_ram_depth = 10'd512;
    localparam logic [9:0] c_afull     = 10'(AFULL_THRESH);
    localparam logic [9:0] c_aempty    = 10'(AEMPTY_THRESH);

    logic [8:0] wr_ptr_q,   wr_ptr_d;
    logic [8:0] rd_ptr_q,   rd_ptr_d;
    logic [9:0] ram_cnt_q,  ram_cnt_d;
    logic       rd_valid_q, rd_valid_d;
    logic       ovf_err_q,  ovf_err_d;

    logic       w_accept;
    logic       w_issue;

    // Readiness looks only at registered occupancy, so a slot freed this cycle
    // is not offered until the next one.
    assign wr_ready = (ram_cnt_q != c_ram_depth) && !rst;
    assign w_accept = wr_valid && wr_ready && !flush;
    assign w_issue  = (ram_cnt_q != 10'd0) && (!rd_valid_q || rd_ready) && !flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ram_cnt_d  = ram_cnt_q;
        rd_valid_d = rd_valid_q;
        ovf_err_d  = ovf_err_q;

        if (flush) begin
            wr_ptr_d   = 9'd0;
            rd_ptr_d   = 9'd0;
            ram_cnt_d  = 10'd0;
            rd_valid_d = 1'b0;
            ovf_err_d  = 1'b0;
        end else begin
            if (w_accept) begin
                wr_ptr_d = wr_ptr_q + 9'd1;
            end
            if (w_issue) begin
                rd_ptr_d = rd_ptr_q + 9'd1;
            end
            ram_cnt_d = ram_cnt_q + 10'(w_accept) - 10'(w_issue);

            if (w_issue) begin
                rd_valid_d = 1'b1;
            end else if (rd_valid_q && rd_ready) begin
                rd_valid_d = 1'b0;
            end

            if (wr_valid && !wr_ready) begin
                ovf_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= 9'd0;
            rd_ptr_q   <= 9'd0;
            ram_cnt_q  <= 10'd0;
            rd_valid_q <= 1'b0;
            ovf_err_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            rd_valid_q <= rd_valid_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

    assign ram_ena   = w_accept;
    assign ram_wea   = w_accept;
    assign ram_addra = wr_ptr_q;
    assign ram_dia   = wr_data[31:0];
    assign ram_dipa  = wr_data[35:32];

    // Port B stays disabled unless issuing so its output latch holds the head.
    assign ram_enb   = w_issue;
    assign ram_addrb = rd_ptr_q;

    assign rd_valid  = rd_valid_q;
    assign rd_data   = {ram_dopb, ram_dob};
    assign count     = ram_cnt_q + {9'd0, rd_valid_q};
    assign afull     = (ram_cnt_q >= c_afull);
    assign aempty    = (count <= c_aempty);
    assign ovf_err   = ovf_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ram512x36_fifo_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram512x36_fifo_ctl
// Brief    : Self-checking bench: vector table plus directed multi-cycle
//            sequences, with a behavioural 512x36 dual-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram512x36_fifo_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        wr_valid;
    logic [35:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [35:0] rd_data;
    logic        rd_ready;
    logic [9:0]  count;
    logic        afull;
    logic        aempty;
    logic        ovf_err;
    logic        ram_ena;
    logic        ram_wea;
    logic [8:0]  ram_addra;
    logic [31:0] ram_dia;
    logic [3:0]  ram_dipa;
    logic        ram_enb;
    logic [8:0]  ram_addrb;
    logic [31:0] ram_dob;
    logic [3:0]  ram_dopb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram512x36_fifo_ctl dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .count     (count),
        .afull     (afull),
        .aempty    (aempty),
        .ovf_err   (ovf_err),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dia   (ram_dia),
        .ram_dipa  (ram_dipa),
        .ram_enb   (ram_enb),
        .ram_addrb (ram_addrb),
        .ram_dob   (ram_dob),
        .ram_dopb  (ram_dopb)
    );

    // Behavioural block RAM: port A write, port B registered read with hold.
    logic [35:0] mem [512];
    always @(posedge clk) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= {ram_dipa, ram_dia};
        if (ram_enb) {ram_dopb, ram_dob} <= mem[ram_addrb];
    end

    typedef struct {
        logic        wv;
        logic [35:0] wd;
        logic        rr;
        logic        fl;
        logic        x_ena;
        logic        x_enb;
        logic        x_rv;
        logic [35:0] x_rd;
        logic [9:0]  x_cnt;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wv, input logic [35:0] wd, input logic rr, input logic fl);
        @(negedge clk);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] fword(input int n);
        return {4'(n), 32'h5000_0000 + 32'(n)};
    endfunction

    function automatic logic [35:0] sword(input int n);
        return {4'(n * 7), 32'(n)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int rcv;

        vt[0] = '{1'b1, 36'h000000001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 36'h0,         10'd1};
        vt[1] = '{1'b0, 36'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 36'h000000001, 10'd1};
        vt[2] = '{1'b1, 36'hA12345678, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 36'h000000001, 10'd2};
        vt[3] = '{1'b1, 36'h5DEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 36'hA12345678, 10'd2};
        vt[4] = '{1'b0, 36'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 36'h5DEADBEEF, 10'd1};
        vt[5] = '{1'b0, 36'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 36'h0,         10'd0};
        vt[6] = '{1'b1, 36'h3CAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 36'h0,         10'd0};
        vt[7] = '{1'b0, 36'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 36'h0,         10'd0};

        rst = 1'b1; flush = 1'b0; wr_valid = 1'b1; wr_data = 36'h0; rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_ready", 36'(wr_ready), 36'd0);
        chk("rst_count",    36'(count),    36'd0);
        chk("rst_rd_valid", 36'(rd_valid), 36'd0);
        chk("rst_afull",    36'(afull),    36'd0);
        chk("rst_aempty",   36'(aempty),   36'd1);
        chk("rst_ovf",      36'(ovf_err),  36'd0);
        chk("rst_ena",      36'(ram_ena),  36'd0);
        chk("rst_enb",      36'(ram_enb),  36'd0);
        wr_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_wr_ready", 36'(wr_ready), 36'd1);

        // Basic transfer, stall, simultaneous wr/rd and flush-discard vectors.
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].wv, vt[i].wd, vt[i].rr, vt[i].fl);
            chk($sformatf("vec%0d_ena", i), 36'(ram_ena), 36'(vt[i].x_ena));
            chk($sformatf("vec%0d_enb", i), 36'(ram_enb), 36'(vt[i].x_enb));
            edge_wait();
            chk($sformatf("vec%0d_rd_valid", i), 36'(rd_valid), 36'(vt[i].x_rv));
            chk($sformatf("vec%0d_count", i),    36'(count),    36'(vt[i].x_cnt));
            if (vt[i].x_rv) chk($sformatf("vec%0d_rd_data", i), rd_data, vt[i].x_rd);
        end

        // Fill to 513 with reads stalled; watch threshold boundaries.
        for (int n = 1; n <= 513; n++) begin
            drive(1'b1, fword(n - 1), 1'b0, 1'b0);
            chk("fill_wr_ready", 36'(wr_ready), 36'd1);
            edge_wait();
            if (n == 16)  chk("fill16_aempty",  36'(aempty), 36'd1);
            if (n == 17)  chk("fill17_aempty",  36'(aempty), 36'd0);
            if (n == 480) chk("fill480_afull",  36'(afull),  36'd0);
            if (n == 481) chk("fill481_afull",  36'(afull),  36'd1);
            if (n == 481) chk("fill481_count",  36'(count),  36'd481);
        end
        chk("full_wr_ready", 36'(wr_ready), 36'd0);
        chk("full_count",    36'(count),    36'd513);
        chk("full_afull",    36'(afull),    36'd1);
        chk("full_ovf_pre",  36'(ovf_err),  36'd0);
        drive(1'b1, 36'hFFFFFFFFF, 1'b0, 1'b0);
        chk("full_ena", 36'(ram_ena), 36'd0);
        edge_wait();
        chk("full_ovf",     36'(ovf_err),  36'd1);
        chk("full_count2",  36'(count),    36'd513);
        chk("full_head_rv", 36'(rd_valid), 36'd1);
        chk("full_head",    rd_data,       fword(0));
        drive(1'b0, 36'h0, 1'b0, 1'b1);
        edge_wait();
        chk("flush_full_count", 36'(count),    36'd0);
        chk("flush_full_ovf",   36'(ovf_err),  36'd0);
        chk("flush_full_rv",    36'(rd_valid), 36'd0);
        chk("flush_full_wrdy",  36'(wr_ready), 36'd1);
        chk("flush_full_afull", 36'(afull),    36'd0);

        // Continuous streaming across several pointer wraps.
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < 2600 && rcv < 2000; c++) begin
            drive(sent < 2000, sword(sent), 1'b1, 1'b0);
            if (rcv >= 1 && sent < 2000) begin
                chk("stream_rd_valid", 36'(rd_valid), 36'd1);
                chk("stream_count",    36'(count),    36'd2);
            end
            if (rd_valid) begin
                chk("stream_data", rd_data, sword(rcv));
                rcv++;
            end
            if (wr_valid && wr_ready) sent++;
        end
        chk("stream_done", 36'(rcv), 36'd2000);
        drive(1'b0, 36'h0, 1'b0, 1'b0);
        edge_wait();
        chk("stream_empty", 36'(count), 36'd0);

        // Head held while consumer stalls.
        drive(1'b1, 36'h9ABCDEF01, 1'b0, 1'b0);
        edge_wait();
        drive(1'b1, 36'h623456789, 1'b0, 1'b0);
        edge_wait();
        chk("stall_rv0", 36'(rd_valid), 36'd1);
        chk("stall_d0",  rd_data, 36'h9ABCDEF01);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 36'h0, 1'b0, 1'b0);
            chk("stall_enb", 36'(ram_enb), 36'd0);
            edge_wait();
            chk("stall_data", rd_data, 36'h9ABCDEF01);
        end

        // Bring occupancy to 100, then flush with a write pending.
        for (int k = 0; k < 98; k++) begin
            drive(1'b1, fword(1000 + k), 1'b0, 1'b0);
            edge_wait();
        end
        chk("pre_flush_count", 36'(count), 36'd100);
        drive(1'b1, 36'h7BADBAD00, 1'b0, 1'b1);
        edge_wait();
        chk("flush_count", 36'(count),    36'd0);
        chk("flush_rv",    36'(rd_valid), 36'd0);
        chk("flush_ovf",   36'(ovf_err),  36'd0);
        drive(1'b1, 36'h811112222, 1'b0, 1'b0);
        edge_wait();
        chk("post_flush_count", 36'(count), 36'd1);
        drive(1'b0, 36'h0, 1'b0, 1'b0);
        edge_wait();
        chk("post_flush_rv",   36'(rd_valid), 36'd1);
        chk("post_flush_data", rd_data, 36'h811112222);

        // Asynchronous reset mid-burst at occupancy 50.
        drive(1'b0, 36'h0, 1'b1, 1'b0);
        edge_wait();
        for (int k = 0; k < 50; k++) begin
            drive(1'b1, fword(3000 + k), 1'b0, 1'b0);
            edge_wait();
        end
        chk("pre_rst_count", 36'(count), 36'd50);
        drive(1'b1, fword(3050), 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", 36'(count),    36'd0);
        chk("async_rst_rv",    36'(rd_valid), 36'd0);
        chk("async_rst_wrdy",  36'(wr_ready), 36'd0);
        chk("async_rst_ena",   36'(ram_ena),  36'd0);
        edge_wait();
        chk("held_rst_count", 36'(count), 36'd0);
        @(negedge clk);
        rst      = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 36'h4CCCC3333;
        #1;
        chk("rel_wr_ready", 36'(wr_ready), 36'd1);
        chk("rel_ena",      36'(ram_ena),  36'd1);
        edge_wait();
        chk("rel_rv1",  36'(rd_valid), 36'd0);
        chk("rel_cnt1", 36'(count),    36'd1);
        chk("rel_ovf",  36'(ovf_err),  36'd0);
        drive(1'b0, 36'h0, 1'b0, 1'b0);
        edge_wait();
        chk("rel_rv2",   36'(rd_valid), 36'd1);
        chk("rel_data2", rd_data, 36'h4CCCC3333);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram512x36_fifo_ctl.md
RAM512X36_FIFO_CTL -- requirements
Module: ram512x36_fifo_ctl

Interface
REQ-001 SHALL have parameter AFULL_THRESH, default 480, RAM occupancy at or above which afull asserts.
REQ-002 SHALL have parameter AEMPTY_THRESH, default 16, total occupancy at or below which aempty asserts.
REQ-003 clk  in  1  sole clock; all state and both RAM ports use its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 flush  in  1  synchronous clear of all queued data.
REQ-006 wr_valid  in  1  write request.
REQ-007 wr_data  in  36  write word; [35:32] parity, [31:0] data.
REQ-008 wr_ready  out  1  write accepted when wr_valid && wr_ready.
REQ-009 rd_valid  out  1  rd_data holds the head word.
REQ-010 rd_data  out  36  head word, {ram_dopb, ram_dob}.
REQ-011 rd_ready  in  1  head consumed when rd_valid && rd_ready.
REQ-012 count  out  10  total occupancy, 0..513.
REQ-013 afull / aempty  out  1 each  threshold flags.
REQ-014 ovf_err  out  1  sticky: wr_valid seen while wr_ready low.
REQ-015 ram_ena, ram_wea  out  1 each  port A enable/write-enable.
REQ-016 ram_addra  out  9  port A address; ram_dia out 32, ram_dipa out 4: write data/parity.
REQ-017 ram_enb  out  1  port B read enable; ram_addrb out 9 read address.
REQ-018 ram_dob in 32, ram_dopb in 4: port B read data, valid the cycle after ram_enb.

Function
REQ-019 SHALL treat port A as write-only and port B as read-only; WEB, SSRA, SSRB SHALL be tied 0 by the integrator, DIB/DIPB unused.
REQ-020 SHALL keep 9-bit wr_ptr, rd_ptr (wrapping 511->0) and 10-bit ram_cnt (0..512) of committed RAM words.
REQ-021 wr_ready SHALL equal (ram_cnt != 512) && !rst, from registered state only; no same-cycle pass of a freed slot.
REQ-022 On accept: ram_ena=ram_wea=1, ram_addra=wr_ptr, ram_dia=wr_data[31:0], ram_dipa=wr_data[35:32]; wr_ptr increments; ram_ena=ram_wea=0 otherwise.
REQ-023 Read issue SHALL occur when ram_cnt != 0 && (!rd_valid || rd_ready) && !flush: ram_enb=1, ram_addrb=rd_ptr, rd_ptr increments.
REQ-024 ram_enb SHALL be 0 when not issuing so the RAM output latch holds rd_data stable while rd_valid && !rd_ready.
REQ-025 rd_valid next = issue, if issue; else 0 if rd_ready consumed head; else hold.
REQ-026 ram_cnt next = ram_cnt + accept - issue; simultaneous accept and issue leaves it unchanged.
REQ-027 count SHALL equal ram_cnt + rd_valid.
REQ-028 Write-to-rd_valid latency into an empty block SHALL be 2 cycles; sustained throughput 1 word/cycle each side.
REQ-029 Port B never reads an address being written the same cycle (only committed words are read); no collision case exists.
REQ-030 afull = (ram_cnt >= AFULL_THRESH); aempty = (count <= AEMPTY_THRESH); both from registered state.
REQ-031 ovf_err SHALL set on wr_valid && !wr_ready (outside rst) and clear only on flush or rst.
REQ-032 flush SHALL on the next edge zero wr_ptr, rd_ptr, ram_cnt, rd_valid, ovf_err; writes and issues in the flush cycle are discarded/suppressed.
REQ-033 Word order out SHALL equal accepted order across pointer wrap.

Reset
REQ-034 While rst high: wr_ptr=rd_ptr=0, ram_cnt=0, rd_valid=0, ovf_err=0, wr_ready=0, all RAM enables 0, count=0, afull=0, aempty=1.
REQ-035 rst asserted mid-traffic SHALL drop all queued data immediately; first cycle after release wr_ready=1.

Verification
REQ-036 Empty, write 0x0_00000001 at cycle 0 -> rd_valid=1, rd_data=0x0_00000001 at cycle 2, count=1.
REQ-037 Write 513 words with rd_ready=0 -> wr_ready=0 after 513th accepted, count=513, afull=1; extra write sets ovf_err.
REQ-038 Continuous wr/rd 2000 words, incrementing data -> output in order across wraps, no gaps after fill, count steady.
REQ-039 Head valid, rd_ready=0 for 5 cycles -> rd_data unchanged, ram_enb=0 throughout.
REQ-040 count=100, flush with wr_valid high -> next cycle count=0, rd_valid=0, ovf_err=0, flush-cycle word absent.
REQ-041 rst pulse mid-burst at count=50 -> count=0 immediately, wr_ready=1 cycle after release, first new word returns in 2 cycles.
